// File: rtl/uart_rx.sv
// 8N1 UART receiver with a receive FIFO, status/control registers and a level irq.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx #(
    parameter int unsigned ClockFrequency = 50_000_000,
    parameter int unsigned BaudRate       = 115_200,
    parameter int unsigned FifoDepth      = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    input  logic        uart_rx_i,
    output logic        uart_rx_irq_o
);
    localparam int unsigned ClksPerBit = ClockFrequency / BaudRate;
    localparam int unsigned CntW       = $clog2(ClksPerBit);
    localparam int unsigned AW         = $clog2(FifoDepth);
    localparam logic [CntW-1:0] HalfLoad = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] BitLoad  = CntW'(ClksPerBit - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT
`ifdef UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_e;

    state_e          r_state, w_state_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_sync1, r_sync2, r_sync3;
    logic            w_fall, w_tick, w_push, w_set_ferr, w_set_perr;
`ifdef UART_RX_PARITY_EN
    logic            r_par_bad, w_par_bad_nxt;
`endif

    logic [7:0]      r_mem [FifoDepth];
    logic [AW:0]     r_wptr, r_rptr, w_count;
    logic            w_empty, w_full, w_pop, w_push_ok, w_set_ovf;
    logic            r_ovf, r_ferr, r_perr, r_irq_en, r_irq, r_rvalid;
    logic [31:0]     r_rdata, w_rdata, w_status;
    logic            w_rd, w_sts_wr, w_ctrl_wr, w_irq_cond;
    logic            w_unused;

    assign w_fall = r_sync3 & ~r_sync2;
    assign w_tick = (r_cnt == '0);

    // Counter free-runs down to zero in every state; states only act on the tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_tick ? r_cnt : r_cnt - 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_set_ferr  = 1'b0;
        w_set_perr  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
`endif
        case (r_state)
            S_IDLE: if (w_fall) begin
                w_cnt_nxt   = HalfLoad;
                w_state_nxt = S_START;
            end
            S_START: if (w_tick) begin
                if (r_sync2) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = BitLoad;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: if (w_tick) begin
                w_shift_nxt[r_idx] = r_sync2;
                w_cnt_nxt          = BitLoad;
                w_idx_nxt          = r_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                if (r_idx == 3'd7) w_state_nxt = S_PARITY;
`else
                if (r_idx == 3'd7) w_state_nxt = S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (w_tick) begin
                w_par_bad_nxt = (^r_shift) ^ r_sync2;
                w_set_perr    = w_par_bad_nxt;
                w_cnt_nxt     = BitLoad;
                w_state_nxt   = S_STOP;
            end
`endif
            S_STOP: if (w_tick) begin
                if (r_sync2) begin
`ifdef UART_RX_PARITY_EN
                    w_push = ~r_par_bad;
`else
                    w_push = 1'b1;
`endif
                    w_state_nxt = S_IDLE;
                end else begin
                    w_set_ferr  = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: if (r_sync2) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_sync1 <= uart_rx_i;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nxt;
`endif
        end
    end

    assign w_count   = r_wptr - r_rptr;
    assign w_empty   = (w_count == '0);
    assign w_full    = (w_count == (AW+1)'(FifoDepth));
    assign w_rd      = device_req_i & ~device_we_i;
    assign w_pop     = w_rd & (device_addr_i[3:2] == 2'd0) & ~w_empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_set_ovf = w_push & w_full & ~w_pop;
    assign w_sts_wr  = device_req_i & device_we_i & device_be_i[0] & (device_addr_i[3:2] == 2'd1);
    assign w_ctrl_wr = device_req_i & device_we_i & device_be_i[0] & (device_addr_i[3:2] == 2'd2);
    assign w_status  = {16'h0, 8'(w_count), 3'b0, r_perr, r_ferr, r_ovf, w_full, w_empty};
`ifdef UART_RX_PARITY_EN
    assign w_irq_cond = r_irq_en & (~w_empty | r_ovf | r_ferr | r_perr);
`else
    assign w_irq_cond = r_irq_en & (~w_empty | r_ovf | r_ferr);
`endif
    assign w_unused = ^{device_addr_i[31:4], device_addr_i[1:0], device_be_i[3:1],
                        device_wdata_i[31:5], device_wdata_i[1]};

    always_comb begin
        w_rdata = '0;
        case (device_addr_i[3:2])
            2'd0:    w_rdata = w_empty ? '0 : {24'h0, r_mem[r_rptr[AW-1:0]]};
            2'd1:    w_rdata = w_status;
            2'd2:    w_rdata = {31'h0, r_irq_en};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= r_shift;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_ovf    <= 1'b0;
            r_ferr   <= 1'b0;
            r_perr   <= 1'b0;
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            r_ovf  <= w_set_ovf  | (r_ovf  & ~(w_sts_wr & device_wdata_i[2]));
            r_ferr <= w_set_ferr | (r_ferr & ~(w_sts_wr & device_wdata_i[3]));
            r_perr <= w_set_perr | (r_perr & ~(w_sts_wr & device_wdata_i[4]));
            if (w_ctrl_wr) r_irq_en <= device_wdata_i[0];
            r_irq    <= w_irq_cond;
            r_rvalid <= device_req_i;
            r_rdata  <= w_rd ? w_rdata : '0;
        end
    end

    assign device_rvalid_o = r_rvalid;
    assign device_rdata_o  = r_rdata;
    assign uart_rx_irq_o   = r_irq;
endmodule
